dram_frame_writer: RTL

Requester-side client of the SDRAM controller's write port. It accepts RGB565 pixels from the camera capture path and buffers them in a small FIFO. For each word it generates a linear bank/row address and drives the controller's four-phase DRAMWriteReq/DRAMWriteAck handshake. It sits between camera capture and the SDRAM controller, and signals frame completion and overflow to the frame-sync logic.

---
 rtl/dram_frame_writer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/dram_frame_writer.sv
// rtl/dram_frame_writer.sv - camera pixel FIFO feeding the SDRAM controller write port
//
// Buffers RGB565 pixels in a small FIFO and writes each one to SDRAM at a
// linear word index via the controller's four-phase DRAMWriteReq/DRAMWriteAck
// handshake. It also reports frame completion and dropped pixels.
//
// Optional feature macro: DRAM_WR_DROP_CNT_EN enables the dropCount port.
//
// Ports:
//   CLK100MHz     in   system clock, rising edge
//   resetN        in   asynchronous active-low reset
//   pixValid      in   pixData strobe, no backpressure
//   pixData       in   RGB565 pixel
//   frameStart    in   restart frame at word 0, flush FIFO
//   DRAMWriteAck  in   controller acknowledge
//   DRAMWriteReq  out  write request
//   rowAddress    out  word index bits [12:0]
//   bankAddress   out  word index bits [14:13]
//   dataToDRAM    out  write data, stable while DRAMWriteReq=1
//   busy          out  transaction in flight or FIFO non-empty
//   frameDone     out  one-cycle pulse when the last word of a frame completes
//   fifoOverflow  out  sticky dropped-pixel flag
//   dropCount     out  saturating dropped-pixel count (DRAM_WR_DROP_CNT_EN only)

module dram_frame_writer #(
    parameter int FIFO_DEPTH  = 8,
    parameter int FRAME_WORDS = 19200
) (
    input  logic        CLK100MHz,
    input  logic        resetN,
    input  logic        pixValid,
    input  logic [15:0] pixData,
    input  logic        frameStart,
    input  logic        DRAMWriteAck,
    output logic        DRAMWriteReq,
    output logic [12:0] rowAddress,
    output logic [1:0]  bankAddress,
    output logic [15:0] dataToDRAM,
    output logic        busy,
    output logic        frameDone,
    output logic        fifoOverflow
`ifdef DRAM_WR_DROP_CNT_EN
    ,
    output logic [15:0] dropCount
`endif
);

    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [14:0] LAST_IDX = 15'(FRAME_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t state, next_state;

    logic [15:0] fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        fifo_empty, fifo_full;
    logic        push, pop, drop, complete;

    logic [14:0] word_idx;
    logic [14:0] addr_q;
    logic        restart_pending;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A frameStart flush empties the FIFO before this cycle's pixel lands,
    // so the pixel is always accepted then. A pop frees a slot in the same
    // cycle, so a full FIFO still accepts.
    assign push = pixValid && (frameStart || !fifo_full || pop);
    assign drop = pixValid && !push;

    // State register
    always_ff @(posedge CLK100MHz or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE:    next_state = pop ? REQ : IDLE;
            REQ:     next_state = DRAMWriteAck ? RELEASE : REQ;
            RELEASE: next_state = DRAMWriteAck ? RELEASE : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output / control decode. A flush in the same cycle suppresses the pop
    // so a flushed pixel is never written.
    always_comb begin
        DRAMWriteReq = (state == REQ);
        busy         = (state != IDLE) || !fifo_empty;
        pop          = (state == IDLE) && !fifo_empty && !frameStart;
        complete     = (state == RELEASE) && !DRAMWriteAck;
    end

    // FIFO storage has no reset; only the pointers define its contents.
    always_ff @(posedge CLK100MHz) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= pixData;
        end
    end

    always_ff @(posedge CLK100MHz or negedge resetN) begin
        if (!resetN) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            dataToDRAM      <= '0;
            addr_q          <= '0;
            word_idx        <= '0;
            restart_pending <= 1'b0;
            frameDone       <= 1'b0;
            fifoOverflow    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW + 1)'(1);
            end

            if (frameStart) begin
                rd_ptr <= wr_ptr;
            end else if (pop) begin
                rd_ptr <= rd_ptr + (AW + 1)'(1);
            end

            if (pop) begin
                dataToDRAM <= fifo_mem[rd_ptr[AW-1:0]];
                addr_q     <= restart_pending ? 15'd0 : word_idx;
            end

            // A pending restart is consumed in IDLE, so a word already in
            // flight keeps its address and the next latched word gets 0.
            if (state == IDLE && restart_pending) begin
                word_idx <= '0;
            end else if (complete) begin
                word_idx <= (word_idx == LAST_IDX) ? 15'd0 : word_idx + 15'd1;
            end

            if (frameStart) begin
                restart_pending <= 1'b1;
            end else if (state == IDLE) begin
                restart_pending <= 1'b0;
            end

            frameDone <= complete && (word_idx == LAST_IDX);

            if (frameStart) begin
                fifoOverflow <= 1'b0;
            end else if (drop) begin
                fifoOverflow <= 1'b1;
            end
        end
    end

`ifdef DRAM_WR_DROP_CNT_EN
    always_ff @(posedge CLK100MHz or negedge resetN) begin
        if (!resetN) begin
            dropCount <= '0;
        end else if (frameStart) begin
            dropCount <= '0;
        end else if (drop && dropCount != 16'hFFFF) begin
            dropCount <= dropCount + 16'd1;
        end
    end
`endif

    assign rowAddress  = addr_q[12:0];
    assign bankAddress = addr_q[14:13];

endmodule
